// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the two-requester data-memory arbiter.
package dmem_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 10;
  localparam int unsigned NREQ = 2;

  localparam logic [1:0] S_FREE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  typedef enum logic [1:0] {
    FREE = S_FREE,
    OWN0 = S_OWN0,
    OWN1 = S_OWN1
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, on contention rr picks the winner.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            rr,
  output logic [NREQ-1:0] gnt_c
);

  always_comb begin
    gnt_c = req;
    if (&req) begin
      gnt_c = rr ? NREQ'(2'b10) : NREQ'(2'b01);
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Arbitrates two requesters onto one single-port-style memory with lockable
// ownership and a one-cycle read-return pipeline.
module dmem_arb #(
  parameter int unsigned DW = dmem_pkg::DW,
  parameter int unsigned AW = dmem_pkg::AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req,
  input  logic [1:0]      lock,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] adr,
  input  logic [2*DW-1:0] wdat,
  output logic [1:0]      gnt,
  output logic [1:0]      rvalid,
  output logic [DW-1:0]   rdat,
  output logic            mem_wr_en,
  output logic [AW-1:0]   mem_wr_adr,
  output logic [DW-1:0]   mem_dat_in,
  output logic [AW-1:0]   mem_rd_adr,
  input  logic [DW-1:0]   mem_dat_out
);

  import dmem_pkg::*;

  state_e        state_q, state_n;
  logic          rr_q, rr_n;
  logic [1:0]    rvalid_q;
  logic [AW-1:0] rd_adr_q;
  logic [1:0]    arb_gnt_c;
  logic [1:0]    acc_c;
  logic          win_c;
  logic [AW-1:0] win_adr_c;
  logic [DW-1:0] win_dat_c;

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .rr    (rr_q),
    .gnt_c (arb_gnt_c)
  );

  // State, pointer and read-return registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FREE;
      rr_q     <= 1'b0;
      rvalid_q <= 2'b00;
      rd_adr_q <= '0;
    end else begin
      state_q  <= state_n;
      rr_q     <= rr_n;
      rvalid_q <= acc_c & ~we;
      rd_adr_q <= mem_rd_adr;
    end
  end

  // Grant selection and next-state; owners keep the bus until an unlocked access
  always_comb begin
    state_n = state_q;
    rr_n    = rr_q;
    gnt     = 2'b00;
    if (!reset) begin
      case (state_q)
        FREE:    gnt = arb_gnt_c;
        OWN0:    gnt = {1'b0, req[0]};
        OWN1:    gnt = {req[1], 1'b0};
        default: state_n = FREE;
      endcase
    end
    acc_c = req & gnt;
    win_c = acc_c[1];
    if (|acc_c) begin
      case (state_q)
        FREE: begin
          rr_n = ~win_c;
          if (lock[win_c]) state_n = win_c ? OWN1 : OWN0;
        end
        default: begin
          if (!lock[win_c]) state_n = FREE;
        end
      endcase
    end
  end

  // Memory-side muxing; read address holds when no read is accepted
  always_comb begin
    win_adr_c  = win_c ? adr[2*AW-1:AW] : adr[AW-1:0];
    win_dat_c  = win_c ? wdat[2*DW-1:DW] : wdat[DW-1:0];
    mem_wr_en  = |(acc_c & we);
    mem_wr_adr = win_adr_c;
    mem_dat_in = win_dat_c;
    mem_rd_adr = (|(acc_c & ~we)) ? win_adr_c : rd_adr_q;
  end

  assign rvalid = rvalid_q;
  assign rdat   = mem_dat_out;

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 Parameter: DW, 16, data width in bits.
REQ-002 Parameter: AW, 10, word-address width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req  input  2  per-requester access request; bit i = requester i.
REQ-006 Port: lock  input  2  per-requester hold-ownership-after-this-access flag.
REQ-007 Port: we  input  2  per-requester write enable; 0 = read.
REQ-008 Port: adr  input  2*AW  requester addresses; bits [AW-1:0] = requester 0.
REQ-009 Port: wdat  input  2*DW  requester write data; bits [DW-1:0] = requester 0.
REQ-010 Port: gnt  output  2  one-hot-or-zero grant; req[i]&gnt[i] = accepted access.
REQ-011 Port: rvalid  output  2  read-data-valid strobe, tagged to the requester.
REQ-012 Port: rdat  output  DW  read data, meaningful only when rvalid != 0.
REQ-013 Port: mem_wr_en  output  1  memory write strobe.
REQ-014 Port: mem_wr_adr  output  AW  memory write address.
REQ-015 Port: mem_dat_in  output  DW  memory write data.
REQ-016 Port: mem_rd_adr  output  AW  memory read address.
REQ-017 Port: mem_dat_out  input  DW  memory read data, registered: valid one cycle after mem_rd_adr.

Function
REQ-018 Grant SHALL be combinational from req, state and priority pointer; at most one gnt bit high per cycle; gnt[i]=0 whenever req[i]=0.
REQ-019 FSM states: FREE, OWN0, OWN1; FREE grants by round-robin, OWNi grants only requester i.
REQ-020 In FREE with both requesting, the requester selected by pointer rr SHALL win; rr resets to 0 (requester 0 first).
REQ-021 After every accepted access in FREE, rr SHALL point to the non-winner on the next cycle.
REQ-022 Accepted access with lock[i]=1 SHALL move the FSM to OWNi; in OWNi an accepted access with lock[i]=0 returns to FREE.
REQ-023 In OWNi, req[i]=0 SHALL keep OWNi (ownership persists through idle cycles); the other requester gets gnt=0.
REQ-024 Accepted write: mem_wr_en=1, mem_wr_adr/mem_dat_in = winner's adr/wdat in the same cycle; mem_wr_en=0 otherwise.
REQ-025 Accepted read: mem_rd_adr = winner's adr in the same cycle; rvalid[winner]=1 and rdat=mem_dat_out exactly one cycle later.
REQ-026 Read latency SHALL be 1 cycle; throughput one access per cycle, back-to-back from either requester, no bubbles.
REQ-027 Read in cycle n+1 of an address written in cycle n SHALL return the new data (write-then-read ordering preserved by the memory).
REQ-028 rvalid SHALL be a single-cycle pulse per accepted read, never for writes; both rvalid bits never high together.
REQ-029 Address values SHALL pass unchanged; no range checks, wrap or translation.
REQ-030 When no access is accepted, mem_rd_adr SHALL hold its previous value.

Reset
REQ-031 On reset assertion (asynchronous): FSM=FREE, rr=0, rvalid=0, mem_rd_adr=0; gnt and mem_wr_en are 0 while reset is high.
REQ-032 Reset during an outstanding read SHALL drop that read; no rvalid after reset deassertion.
REQ-033 First grant possible in the first clock edge after reset deassertion.

Structure
REQ-034 Shared package dmem_pkg SHALL hold DW, AW, requester count (2) and the FSM state enum.
REQ-035 One sub-module, rr_arb2 (2-way round-robin grant from req and rr), is natural; the FSM, read-return pipeline and memory muxing stay in dmem_arb.

Verification
REQ-036 Both req=11, lock=00, reads, 4 cycles -> grants 01,10,01,10; rvalid 01,10,01,10 delayed by one cycle; rdat matches memory contents.
REQ-037 Req0 write adr=0x005 wdat=0xBEEF, next cycle req1 read adr=0x005 -> mem_wr_en pulse, then rvalid=10 with rdat=0xBEEF.
REQ-038 Req0 lock=1 for 3 accesses with req1 held high -> gnt=01 for 3 cycles; req1 granted on cycle after lock=0 access.
REQ-039 OWN1 with req1 idle 5 cycles, req0 high -> gnt=00 throughout; state stays OWN1.
REQ-040 Reset asserted one cycle after an accepted read -> rvalid stays 00; after release, req=10 gets gnt=10 on first edge.
